// File: rtl/namuru_wb_dispatch_if.sv
// Wishbone slave bus plus per-channel request/done fan-out for namuru_wb_dispatch.
interface namuru_wb_dispatch_if #(
  parameter int unsigned NCH   = 12,
  parameter int unsigned CH_AW = 6
);
  logic [31:0]        wb_adr_i;
  logic [31:0]        wb_dat_i;
  logic [31:0]        wb_dat_o;
  logic [3:0]         wb_sel_i;
  logic               wb_stb_i;
  logic               wb_cyc_i;
  logic               wb_we_i;
  logic               wb_ack_o;
  logic [NCH-1:0]     ch_req_o;
  logic               ch_we_o;
  logic [CH_AW-1:0]   ch_adr_o;
  logic [31:0]        ch_dat_o;
  logic [3:0]         ch_sel_o;
  logic [NCH*32-1:0]  ch_dat_i;
  logic [NCH-1:0]     ch_done_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, ch_dat_i, ch_done_i,
    output wb_dat_o, wb_ack_o, ch_req_o, ch_we_o, ch_adr_o, ch_dat_o, ch_sel_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, ch_dat_i, ch_done_i,
    input  wb_dat_o, wb_ack_o, ch_req_o, ch_we_o, ch_adr_o, ch_dat_o, ch_sel_o
  );
endinterface

// File: rtl/namuru_wb_dispatch.sv
// Wishbone dispatcher: routes accesses to NCH correlator channel windows or a
// global status block, with bounded channel handshakes and a dump interrupt.
module namuru_wb_dispatch #(
  parameter int unsigned NCH     = 12,
  parameter int unsigned CH_AW   = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  namuru_wb_dispatch_if.slave    bus,
  input  logic [NCH-1:0]         dump_i,
  output logic                   accum_int
);

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CH_AW-1:0] OFF_STATUS = CH_AW'(0);
  localparam logic [CH_AW-1:0] OFF_MASK   = CH_AW'(1);
  localparam logic [CH_AW-1:0] OFF_TMO    = CH_AW'(2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [NCH-1:0]   req_q, req_d;
  logic [NCH-1:0]   chsel_q, chsel_d;
  logic             we_q, we_d;
  logic [CH_AW-1:0] adr_q, adr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [3:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]   status_q, status_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             irq_q, irq_d;

  logic [CH_AW-1:0] off_c;
  logic [IW-1:0]    idx_c;
  logic             is_ch_c, is_glb_c, done_c;
  logic [31:0]      glb_rdata_c, ch_rdata_c, wmask_c;
  logic [NCH-1:0]   clr_c;
  logic             unused_adr_c;

  // Address decode; bits outside the window/index fields are don't-care
  assign off_c        = bus.wb_adr_i[CH_AW+1:2];
  assign idx_c        = bus.wb_adr_i[CH_AW+5:CH_AW+2];
  assign is_ch_c      = 32'(idx_c) < NCH;
  assign is_glb_c     = 32'(idx_c) == NCH;
  assign unused_adr_c = ^{bus.wb_adr_i[31:CH_AW+6], bus.wb_adr_i[1:0]};
  assign wmask_c      = {{8{bus.wb_sel_i[3]}}, {8{bus.wb_sel_i[2]}},
                         {8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};
  assign done_c       = |(bus.ch_done_i & chsel_q);

  always_comb begin
    glb_rdata_c = '0;
    if (off_c == OFF_STATUS)    glb_rdata_c = 32'(status_q);
    else if (off_c == OFF_MASK) glb_rdata_c = 32'(mask_q);
    else if (off_c == OFF_TMO)  glb_rdata_c = 32'(tmo_q);
  end

  always_comb begin
    ch_rdata_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chsel_q[i]) ch_rdata_c = ch_rdata_c | bus.ch_dat_i[i*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    req_d   = '0;
    chsel_d = chsel_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    clr_c   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          if (is_ch_c) begin
            state_d = S_REQ;
            req_d   = NCH'(1) << idx_c;
            chsel_d = NCH'(1) << idx_c;
            we_d    = bus.wb_we_i;
            adr_d   = off_c;
            wdat_d  = bus.wb_dat_i;
            sel_d   = bus.wb_sel_i;
            cnt_d   = '0;
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (is_glb_c && bus.wb_we_i) begin
              if (off_c == OFF_MASK) begin
                mask_d = (mask_q & ~wmask_c[NCH-1:0]) | (bus.wb_dat_i[NCH-1:0] & wmask_c[NCH-1:0]);
              end
            end else if (is_glb_c) begin
              dat_d = glb_rdata_c;
              // Clear exactly what the reader saw; dumps landing now survive
              if (off_c == OFF_STATUS) clr_c = status_q;
            end
          end
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (done_c) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = we_q ? 32'h0 : ch_rdata_c;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = 32'hFFFF_FFFF;
          tmo_d   = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    status_d = (status_q & ~clr_c) | dump_i;
    irq_d    = |(status_d & mask_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      req_q    <= '0;
      chsel_q  <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      req_q    <= req_d;
      chsel_q  <= chsel_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      tmo_q    <= tmo_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.ch_req_o = req_q;
  assign bus.ch_we_o  = we_q;
  assign bus.ch_adr_o = adr_q;
  assign bus.ch_dat_o = wdat_q;
  assign bus.ch_sel_o = sel_q;
  assign accum_int    = irq_q;

endmodule

// File: tb/tb_namuru_wb_dispatch.sv
// Self-checking bench for namuru_wb_dispatch: directed scenarios plus random
// traffic checked against a transaction-level model of the register map.
module tb_namuru_wb_dispatch;

  localparam int unsigned NCH     = 12;
  localparam int unsigned CH_AW   = 6;
  localparam int unsigned TIMEOUT = 64;

  logic           sys_clk;
  logic           sys_rst;
  logic [NCH-1:0] dump_i;
  logic           accum_int;

  namuru_wb_dispatch_if #(.NCH(NCH), .CH_AW(CH_AW)) bif ();

  namuru_wb_dispatch #(.NCH(NCH), .CH_AW(CH_AW), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus       (bif),
    .dump_i    (dump_i),
    .accum_int (accum_int)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the global register block
  logic [NCH-1:0] m_status;
  logic [NCH-1:0] m_mask;
  int             m_tmo;

  function automatic logic [31:0] mk_adr(input int idx, input int off);
    return (32'($urandom) & 32'hFFFF_F003) | (32'(idx) << 8) | (32'(off) << 2);
  endfunction

  task automatic model_reset();
    m_status = '0;
    m_mask   = '0;
    m_tmo    = 0;
  endtask

  task automatic idle_bus();
    bif.wb_cyc_i  = 1'b0;
    bif.wb_stb_i  = 1'b0;
    bif.wb_we_i   = 1'b0;
    bif.wb_adr_i  = '0;
    bif.wb_dat_i  = '0;
    bif.wb_sel_i  = '0;
    bif.ch_done_i = '0;
  endtask

  // One bus access; latency counted in cycles from the first sampling edge.
  task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, input int done_at, input logic [NCH-1:0] dump0,
                           input logic noise,
                           output logic [31:0] rdat, output int lat, output logic [NCH-1:0] req_seen,
                           output int req_cyc, output logic irq_at_ack, output logic post_ok);
    int idx;
    logic [NCH-1:0] own;
    idx = int'(adr[11:8]);
    own = (idx < NCH) ? (NCH'(1) << idx) : '0;
    bif.wb_adr_i = adr;
    bif.wb_we_i  = we;
    bif.wb_dat_i = wdat;
    bif.wb_sel_i = sel;
    bif.wb_cyc_i = 1'b1;
    bif.wb_stb_i = 1'b1;
    dump_i       = dump0;
    lat = -1; rdat = '0; req_seen = '0; req_cyc = 0; irq_at_ack = 1'b0; post_ok = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge sys_clk);
      dump_i = '0;
      if (bif.ch_req_o != '0) begin
        req_seen = req_seen | bif.ch_req_o;
        req_cyc++;
      end
      if (bif.wb_ack_o) begin
        lat = k; rdat = bif.wb_dat_o; irq_at_ack = accum_int;
        break;
      end
      bif.ch_done_i = noise ? (NCH'($urandom) & ~own) : '0;
      if (done_at >= 0 && k == 1 + done_at) bif.ch_done_i = bif.ch_done_i | own;
    end
    idle_bus();
    @(negedge sys_clk);
    post_ok = !bif.wb_ack_o && (bif.wb_dat_o == 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat, rc; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'hC04, 1'b1, 32'hFFF, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    dump_i = NCH'(12'h010);
    @(negedge sys_clk);
    dump_i = '0;
    n_tests++;
    if (accum_int !== 1'b1) begin n_fail++; $display("FAIL reset_pre_irq: got %b want 1", accum_int); end
    bif.wb_adr_i = 32'h314; bif.wb_we_i = 1'b1; bif.wb_dat_i = 32'hA5A5_5A5A; bif.wb_sel_i = 4'hF;
    bif.wb_cyc_i = 1'b1; bif.wb_stb_i = 1'b1;
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    n_tests++;
    if ({bif.wb_ack_o, bif.wb_dat_o, bif.ch_req_o, bif.ch_we_o, bif.ch_adr_o, bif.ch_dat_o,
         bif.ch_sel_o, accum_int} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b dat=%h req=%h we=%b adr=%h cd=%h sel=%h irq=%b want all 0",
               bif.wb_ack_o, bif.wb_dat_o, bif.ch_req_o, bif.ch_we_o, bif.ch_adr_o, bif.ch_dat_o,
               bif.ch_sel_o, accum_int);
    end
    idle_bus();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    do_access(32'hC04, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_irq_mask: got %h want 0", rd); end
  endtask

  task automatic test_ch_write();
    logic [31:0] rd; int lat, rc; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'h314, 1'b1, 32'h1234_5678, 4'hF, 2, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rq !== NCH'(12'h008) || rc != 1) begin n_fail++; $display("FAIL chw_req: got %h x%0d want 008 x1", rq, rc); end
    n_tests++;
    if (bif.ch_adr_o !== 6'd5 || bif.ch_dat_o !== 32'h1234_5678 || bif.ch_we_o !== 1'b1 || bif.ch_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL chw_latch: got adr=%h dat=%h we=%b sel=%h want 05 12345678 1 f",
               bif.ch_adr_o, bif.ch_dat_o, bif.ch_we_o, bif.ch_sel_o);
    end
    n_tests++;
    if (lat != 4 || rd !== 32'h0 || !po) begin n_fail++; $display("FAIL chw_ack: got lat=%0d dat=%h post=%b want 4 0 1", lat, rd, po); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; int lat, rc; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'h004, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    m_tmo++;
    n_tests++;
    if (lat != 1 + TIMEOUT || rd !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL timeout_ack: got lat=%0d dat=%h want %0d ffffffff", lat, rd, 1 + TIMEOUT);
    end
    do_access(32'hC08, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rd !== 32'(m_tmo)) begin n_fail++; $display("FAIL timeout_count: got %h want %h", rd, m_tmo); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat, rc; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'hC04, 1'b1, 32'h004, 4'h3, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    m_mask = NCH'(12'h004);
    dump_i = NCH'(12'h004);
    @(negedge sys_clk);
    dump_i = '0;
    m_status = m_status | NCH'(12'h004);
    n_tests++;
    if (accum_int !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", accum_int); end
    do_access(32'hC00, 1'b0, '0, 4'hF, -1, NCH'(12'h020), 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rd !== 32'h004 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_read: got dat=%h irq=%b want 004 0", rd, irq); end
    do_access(32'hC00, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    m_status = '0;
    n_tests++;
    if (rd !== 32'h020 || accum_int !== 1'b0) begin n_fail++; $display("FAIL irq_survivor: got dat=%h irq=%b want 020 0", rd, accum_int); end
  endtask

  task automatic test_done_in_req();
    logic [31:0] rd; int lat, rc; logic [NCH-1:0] rq; logic irq, po;
    for (int i = 0; i < NCH; i++) bif.ch_dat_i[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
    do_access(32'h708, 1'b0, '0, 4'hF, 0, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (lat != 2 || rd !== 32'hC0DE_0007) begin n_fail++; $display("FAIL done_in_req: got lat=%0d dat=%h want 2 c0de0007", lat, rd); end
  endtask

  task automatic test_invalid_abort();
    logic [31:0] rd; int lat, rc, bad; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'hE00, 1'b0, '0, 4'hF, 0, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (lat != 1 || rd !== 32'h0 || rq !== '0) begin n_fail++; $display("FAIL invalid: got lat=%0d dat=%h req=%h want 1 0 0", lat, rd, rq); end
    bif.wb_adr_i = 32'h208; bif.wb_we_i = 1'b0; bif.wb_sel_i = 4'hF;
    bif.wb_cyc_i = 1'b1; bif.wb_stb_i = 1'b1;
    repeat (5) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 idle_bus();
    bad = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (bif.wb_ack_o || bif.ch_req_o != '0) bad++;
    end
    sys_rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge sys_clk);
      if (bif.wb_ack_o || bif.ch_req_o != '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d ack/req cycles want 0", bad); end
    do_access(32'h10C, 1'b0, '0, 4'hF, 1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (lat != 3 || rd !== 32'hC0DE_0001 || rq !== NCH'(12'h002)) begin
      n_fail++; $display("FAIL abort_recover: got lat=%0d dat=%h req=%h want 3 c0de0001 002", lat, rd, rq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, lat2, rc; logic [NCH-1:0] rq; logic irq, po;
    do_access(32'hC04, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    do_access(32'hC04, 1'b1, 32'h0FF, 4'h1, -1, '0, 1'b0, rd, lat2, rq, rc, irq, po);
    m_mask = NCH'(12'h0FF);
    n_tests++;
    if (lat != 1 || lat2 != 1) begin n_fail++; $display("FAIL back_to_back: got lat=%0d,%0d want 1,1", lat, lat2); end
  endtask

  task automatic test_random();
    logic [31:0] rd, adr, wdat, exp, bm; int lat, rc, kind, idx, off, dly, exp_lat;
    logic [NCH-1:0] rq, p1, p2; logic irq, po, we; logic [3:0] sel;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      we = 1'($urandom); wdat = $urandom; sel = 4'($urandom);
      for (int i = 0; i < NCH; i++) bif.ch_dat_i[i*32 +: 32] = $urandom;
      if (kind <= 2) begin
        idx = int'($urandom_range(0, NCH - 1)); off = int'($urandom_range(0, 63));
        dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
        do_access(mk_adr(idx, off), we, wdat, sel, dly, '0, 1'b1, rd, lat, rq, rc, irq, po);
        exp_lat = (dly < 0) ? 1 + TIMEOUT : 2 + dly;
        exp = (dly < 0) ? 32'hFFFF_FFFF : (we ? 32'h0 : bif.ch_dat_i[idx*32 +: 32]);
        if (dly < 0 && m_tmo < 16'hFFFF) m_tmo++;
        n_tests++;
        if (lat != exp_lat || rd !== exp || rq !== (NCH'(1) << idx) || rc != 1 || !po ||
            bif.ch_adr_o !== 6'(off) || bif.ch_we_o !== we || bif.ch_dat_o !== wdat || bif.ch_sel_o !== sel) begin
          n_fail++;
          $display("FAIL rand_ch it%0d: got lat=%0d dat=%h req=%h x%0d adr=%h want lat=%0d dat=%h ch=%0d off=%0d",
                   it, lat, rd, rq, rc, bif.ch_adr_o, exp_lat, exp, idx, off);
        end
      end else if (kind == 3) begin
        do_access(mk_adr(NCH, 1), 1'b1, wdat, sel, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
        bm = {8'h0, 8'h0, sel[1] ? 8'hFF : 8'h0, sel[0] ? 8'hFF : 8'h0};
        m_mask = NCH'((32'(m_mask) & ~bm) | (wdat & bm));
        n_tests++;
        if (lat != 1 || rq !== '0) begin n_fail++; $display("FAIL rand_mask_wr it%0d: got lat=%0d req=%h want 1 0", it, lat, rq); end
      end else if (kind == 4) begin
        off = int'($urandom_range(0, 3));
        p1 = NCH'($urandom); p2 = NCH'($urandom);
        dump_i = p1;
        @(negedge sys_clk);
        dump_i = '0;
        m_status = m_status | p1;
        n_tests++;
        if (accum_int !== |(m_status & m_mask)) begin
          n_fail++; $display("FAIL rand_irq it%0d: got %b want %b", it, accum_int, |(m_status & m_mask));
        end
        exp = (off == 0) ? 32'(m_status) : (off == 1) ? 32'(m_mask) : (off == 2) ? 32'(m_tmo) : 32'h0;
        do_access(mk_adr(NCH, off), 1'b0, wdat, sel, -1, p2, 1'b0, rd, lat, rq, rc, irq, po);
        if (off == 0) m_status = m_status & ~exp[NCH-1:0];
        m_status = m_status | p2;
        n_tests++;
        if (lat != 1 || rd !== exp || irq !== |(m_status & m_mask)) begin
          n_fail++; $display("FAIL rand_glb_rd it%0d off%0d: got lat=%0d dat=%h irq=%b want 1 %h %b",
                             it, off, lat, rd, irq, exp, |(m_status & m_mask));
        end
      end else begin
        idx = int'($urandom_range(NCH + 1, 15));
        do_access(mk_adr(idx, int'($urandom_range(0, 63))), we, wdat, sel, 0, '0, 1'b1, rd, lat, rq, rc, irq, po);
        n_tests++;
        if (lat != 1 || rd !== 32'h0 || rq !== '0) begin
          n_fail++; $display("FAIL rand_invalid it%0d: got lat=%0d dat=%h req=%h want 1 0 0", it, lat, rd, rq);
        end
      end
    end
    do_access(32'hC04, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rd !== 32'(m_mask)) begin n_fail++; $display("FAIL rand_mask_final: got %h want %h", rd, m_mask); end
    do_access(32'hC08, 1'b0, '0, 4'hF, -1, '0, 1'b0, rd, lat, rq, rc, irq, po);
    n_tests++;
    if (rd !== 32'(m_tmo)) begin n_fail++; $display("FAIL rand_tmo_final: got %h want %h", rd, m_tmo); end
  endtask

  initial begin
    sys_rst = 1'b1;
    dump_i  = '0;
    bif.ch_dat_i = '0;
    idle_bus();
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if ({bif.wb_ack_o, bif.wb_dat_o, bif.ch_req_o, accum_int} !== '0) begin
      n_fail++; $display("FAIL post_reset: got ack=%b dat=%h req=%h irq=%b want 0", bif.wb_ack_o, bif.wb_dat_o, bif.ch_req_o, accum_int);
    end
    test_reset();
    test_ch_write();
    test_timeout();
    test_irq();
    test_done_in_req();
    test_invalid_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/namuru_wb_dispatch.md
Name: namuru_wb_dispatch

Overview:
- Single-clock Wishbone slave that fans out bus accesses to NCH correlator channel register windows and a global status block.
- Each channel access is a one-cycle request/done handshake, bounded by a timeout.
- Latches per-channel accumulator dump pulses into a clear-on-read status register and drives a maskable accumulator interrupt.
- Generalises the single-correlator attachment to N channels with explicit handshaking, error recovery and an interrupt.

Parameters:
- NCH, 12, number of correlator channels (1..15).
- CH_AW, 6, word-address bits per channel window.
- TIMEOUT, 64, maximum wait cycles for ch_done_i before forced ack (2..255).

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_sel_i  in  4  byte enables.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  single-cycle acknowledge.
- ch_req_o  out  NCH  one-hot channel request pulse.
- ch_we_o  out  1  latched write enable.
- ch_adr_o  out  CH_AW  latched register offset.
- ch_dat_o  out  32  latched write data.
- ch_sel_o  out  4  latched byte enables.
- ch_dat_i  in  NCH*32  channel read data; channel i occupies slice [32i+31:32i].
- ch_done_i  in  NCH  channel completion pulse.
- dump_i  in  NCH  accumulator dump pulses.
- accum_int  out  1  level interrupt.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - DUMP_STATUS, IRQ_MASK and TIMEOUT_COUNT are cleared.
  - Reset asserted mid-transaction aborts it: no ack and no further ch_req_o.
- Decode:
  - off = wb_adr_i[CH_AW+1:2].
  - idx = wb_adr_i[CH_AW+5:CH_AW+2].
  - idx < NCH selects a channel.
  - idx == NCH selects the global block.
  - idx > NCH is invalid.
  - Upper address bits are ignored.
- FSM states: IDLE, REQ, WAIT, ACK.
- IDLE:
  - A request is sampled at an edge where wb_cyc_i & wb_stb_i = 1.
  - Global or invalid target: perform the access and go to ACK.
  - Channel target: latch we/off/dat/sel into the ch_* outputs, go to REQ.
- REQ:
  - Exactly one cycle.
  - ch_req_o[idx] = 1; all other bits are 0.
  - ch_done_i[idx] is already sampled in this state.
- WAIT:
  - Counter starts at 0 on entry to REQ and increments every cycle.
  - ch_done_i[idx] = 1: register the ch_dat_i slice into wb_dat_o (writes: wb_dat_o = 0) and go to ACK.
  - Counter reaches TIMEOUT with no done: wb_dat_o = 32'hFFFFFFFF, TIMEOUT_COUNT increments (saturates at 0xFFFF), go to ACK.
  - ch_done_i bits for non-selected channels are ignored.
- ACK:
  - wb_ack_o = 1 for exactly one cycle, then IDLE.
  - wb_dat_o returns to 0 after the ack cycle.
  - A new request can be sampled at the first edge in IDLE.
- Latency:
  - Global/invalid: ack in the cycle after the sampling edge (1 wait state).
  - Channel: ack in the cycle after the edge where done is sampled.
- Global block (off values):
  - 0 DUMP_STATUS, R: latched dump bits (NCH LSBs, upper bits 0).
  - 1 IRQ_MASK, RW: NCH bits, byte-enable honoured on write.
  - 2 TIMEOUT_COUNT, RO: 16 bits, zero-extended.
  - Other offsets read 0; writes ignored.
- Invalid target: reads return 0, writes are ignored, no ch_req_o.
- DUMP_STATUS update, every cycle: status <= (status & ~clr) | dump_i.
  - clr = the value returned by a DUMP_STATUS read, applied on the ack-setup edge.
  - A dump arriving in the same cycle as its clear stays set.
- accum_int: registered, equal to |(status_next & IRQ_MASK). It deasserts the cycle after the clearing read.
- Dropped strobe: if wb_stb_i drops while in REQ/WAIT, the transaction still completes internally; the ack is issued but ignored.

Test Plan:
- Reset: pulse sys_rst asynchronously between clock edges -> all outputs 0 immediately; reading IRQ_MASK (adr 0xC04, NCH=12) returns 0.
- Write ch3 off5 0x12345678 sel 0xF; done 2 cycles after req:
  - ch_req_o = 0x008 for one cycle.
  - ch_adr_o = 5, ch_dat_o = 0x12345678, ch_we_o = 1.
  - wb_ack_o for one cycle, in the cycle after done is sampled.
- Read ch0 off1 with no done, TIMEOUT=64 -> ack 64 cycles after REQ entry, wb_dat_o = 0xFFFFFFFF; TIMEOUT_COUNT then reads 1.
- IRQ_MASK = 0x004, dump_i[2] pulse:
  - accum_int = 1 the next cycle.
  - Read DUMP_STATUS -> 0x004, then accum_int falls.
  - dump_i[5] pulse in the clear cycle leaves status = 0x020 and accum_int = 0.
- Read ch7 with done asserted during REQ -> ack on the following cycle with ch_dat_i[255:224].
- Invalid and abort:
  - Access idx 14 -> ack, dat 0, ch_req_o stays 0.
  - Reset during WAIT -> no ack; the next access behaves normally.
